// File: rtl/sll_pipe_pkg.sv
// Shared ALU constants and helpers for the pipelined left shifter.
package sll_pipe_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGES  = SHAMT_W;

    // Any set bit above the 5-bit shift field pushes every data bit out.
    function automatic logic is_oversize(input logic [XLEN-1:0] amt);
        return |amt[XLEN-1:SHAMT_W];
    endfunction

endpackage

// File: rtl/sll_stage.sv
// One shifter stage: conditional shift by SHIFT, plus valid/tag/residual-amount
// registers that load on advance and hold otherwise.
module sll_stage
    import sll_pipe_pkg::*;
#(
    parameter int SHIFT   = 1,
    parameter int TAG_W   = 4,
    parameter bit ZERO_EN = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               adv_i,
    input  logic               vld_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  logic               zero_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               vld_o,
    output logic [XLEN-1:0]    data_o,
    output logic [SHAMT_W-1:0] amt_o,
    output logic               zero_o,
    output logic [TAG_W-1:0]   tag_o
);

    logic               vld_q;
    logic [XLEN-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic               zero_q;
    logic [TAG_W-1:0]   tag_q;

    // Bit 0 of the residual amount selects this stage's shift; the rest moves on.
    always_comb begin
        data_d = amt_i[0] ? (data_i << SHIFT) : data_i;
        if (ZERO_EN && zero_i) data_d = '0;
        amt_d = amt_i >> 1;
    end

    // Valid follows the advance/flush rules; payload only loads for a real op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
            zero_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            if (flush_i)    vld_q <= 1'b0;
            else if (adv_i) vld_q <= vld_i;
            if (adv_i && vld_i) begin
                data_q <= data_d;
                amt_q  <= amt_d;
                zero_q <= zero_i;
                tag_q  <= tag_i;
            end
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign amt_o  = amt_q;
    assign zero_o = zero_q;
    assign tag_o  = tag_q;

endmodule

// File: rtl/sll_pipe.sv
// Five-stage pipelined 32-bit logical left shifter with valid/ready, flush and tag.
module sll_pipe
    import sll_pipe_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [TAG_W-1:0] out_tag
);

    logic [STAGES-1:0]              vld_q;
    logic [STAGES-1:0]              zero_q;
    logic [STAGES-1:0]              adv;
    logic [STAGES-1:0][WIDTH-1:0]   data_q;
    logic [STAGES-1:0][SHAMT_W-1:0] amt_q;
    logic [STAGES-1:0][TAG_W-1:0]   tag_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic               vld_in;
        logic               zero_in;
        logic [WIDTH-1:0]   data_in;
        logic [SHAMT_W-1:0] amt_in;
        logic [TAG_W-1:0]   tag_in;

        // A stage advances when it or any stage downstream of it has a hole,
        // or the consumer takes the result: the ready chain flattened so it
        // only depends on registered valids and out_ready.
        assign adv[k] = out_ready | ~(&vld_q[STAGES-1:k]);

        if (k == 0) begin : g_head
            assign vld_in  = in_valid;
            assign data_in = in_a;
            assign amt_in  = in_b[SHAMT_W-1:0];
            assign zero_in = is_oversize(in_b);
            assign tag_in  = in_tag;
        end else begin : g_body
            assign vld_in  = vld_q[k-1];
            assign data_in = data_q[k-1];
            assign amt_in  = amt_q[k-1];
            assign zero_in = zero_q[k-1];
            assign tag_in  = tag_q[k-1];
        end

        sll_stage #(
            .SHIFT  (1 << k),
            .TAG_W  (TAG_W),
            .ZERO_EN(k == STAGES - 1)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush_i(flush),
            .adv_i  (adv[k]),
            .vld_i  (vld_in),
            .data_i (data_in),
            .amt_i  (amt_in),
            .zero_i (zero_in),
            .tag_i  (tag_in),
            .vld_o  (vld_q[k]),
            .data_o (data_q[k]),
            .amt_o  (amt_q[k]),
            .zero_o (zero_q[k]),
            .tag_o  (tag_q[k])
        );
    end

    // The last stage's residual amount and zero flag have already been consumed.
    logic unused_tail;
    assign unused_tail = ^{amt_q[STAGES-1], zero_q[STAGES-1]};

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = vld_q[STAGES-1];
    assign out_c     = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_sll_pipe.sv
// Directed + random bench for sll_pipe against an in-order queue model.
module tb_sll_pipe;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, out_c;
    logic [3:0]  in_tag = '0, out_tag;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  tag;
        int          arrive;   // first edge after which the op may be at the output
    } op_t;

    op_t q[$];
    int  edges = 0, total = 0, fails = 0;

    sll_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sll_ref(input logic [31:0] a, input logic [31:0] b);
        return (b > 32'd31) ? 32'h0 : (a << b);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input logic ordy, input logic fl);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Called at a negedge with inputs driven: check outputs, then model one edge.
    task automatic tick();
        logic exp_ov, pop, acc;
        op_t  o;
        #1;
        acc    = in_valid && !flush && (q.size() < 5 || out_ready);
        exp_ov = (q.size() > 0) && (q[0].arrive <= edges);
        chk("in_ready", 32'(in_ready), 32'(!flush && (q.size() < 5 || out_ready)));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_c", out_c, q[0].c);
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
        pop = exp_ov && out_ready;
        o   = '{c: sll_ref(in_a, in_b), tag: in_tag, arrive: 0};
        @(posedge clk);
        edges++;
        if (pop) void'(q.pop_front());
        if (flush) q.delete();
        else begin
            if (pop && q.size() > 0 && q[0].arrive < edges) q[0].arrive = edges;
            if (acc) begin
                o.arrive = edges + 4;
                q.push_back(o);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        drv(1'b0, 32'h0, 32'h0, 4'h0, ordy, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        // Reset values while rst_n is held low
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_c", out_c, 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: 1 << 31, result visible in the fifth cycle after accept for one cycle
        drv(1'b1, 32'h0000_0001, 32'd31, 4'h1, 1'b1, 1'b0);
        tick();
        idle(8, 1'b1);

        // Amount sweep, back to back
        for (int i = 0; i < 32; i++) begin
            drv(1'b1, 32'hDEAD_BEEF, i, 4'(i), 1'b1, 1'b0);
            tick();
        end
        idle(7, 1'b1);

        // Oversize amounts
        drv(1'b1, 32'hFFFF_FFFF, 32'h0000_0020, 4'h2, 1'b1, 1'b0);
        tick();
        drv(1'b1, 32'hFFFF_FFFF, 32'h8000_0003, 4'h3, 1'b1, 1'b0);
        tick();
        idle(7, 1'b1);

        // Backpressure: fill, stall, single-cycle release with a new op
        for (int i = 0; i < 7; i++) begin
            drv(1'b1, $urandom, $urandom_range(0, 31), 4'(i), 1'b0, 1'b0);
            tick();
        end
        drv(1'b1, 32'h1234_5678, 32'd8, 4'h9, 1'b1, 1'b0);
        tick();
        drv(1'b1, 32'h0F0F_0F0F, 32'd4, 4'hA, 1'b0, 1'b0);
        repeat (3) tick();
        idle(9, 1'b1);

        // Flush with three ops in flight and a fourth presented
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, $urandom, $urandom_range(0, 31), 4'(i + 4), 1'b1, 1'b0);
            tick();
        end
        drv(1'b1, 32'hAAAA_5555, 32'd1, 4'h7, 1'b1, 1'b1);
        tick();
        drv(1'b1, 32'h0000_00FF, 32'd12, 4'hC, 1'b1, 1'b0);
        tick();
        idle(8, 1'b1);

        // Random traffic with stalls, oversize amounts and occasional flush
        repeat (400) begin
            drv(($urandom % 4) != 0, $urandom,
                (($urandom % 4) == 0) ? $urandom : ($urandom % 32),
                4'($urandom), ($urandom % 4) != 0, ($urandom % 25) == 0);
            tick();
        end
        idle(9, 1'b1);

        // Asynchronous reset with the pipe full
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, $urandom, $urandom_range(0, 31), 4'(i), 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_c", out_c, 32'h0);
        chk("arst_out_tag", 32'(out_tag), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 32'h0000_0003, 32'd4, 4'h5, 1'b1, 1'b0);
        tick();
        idle(7, 1'b1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
